// File: rtl/d_redu_arbiter.sv
// Round-robin arbiter and tag sequencer sharing one pipelined Dilithium reducer
// among NUM_REQ requesters; results return tagged with the owner id.
module d_redu_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned RED_LAT = 2,
  parameter int unsigned Q       = 8380417,
  parameter int unsigned IDW     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_en,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [48*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  red_in_valid,
  output logic [47:0]           red_in_data,
  input  logic [22:0]           red_out_data,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [22:0]           res_data,
  output logic                  busy,
  output logic                  range_err,
  output logic                  op_err,
  input  logic                  err_clr
);

  localparam int unsigned OPW  = 48;
  localparam int unsigned RESW = 23;
  localparam int unsigned CW   = IDW + 1;
  localparam logic [RESW-1:0] Q_VAL   = RESW'(Q);
  localparam logic [IDW-1:0]  LAST_ID = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]   N_VAL   = CW'(NUM_REQ);

  logic [IDW-1:0]     r_rr_ptr;
  logic [RED_LAT-1:0] r_tag_vld;
  logic [IDW-1:0]     r_tag_id [RED_LAT];
  logic               r_res_valid;
  logic [IDW-1:0]     r_res_id;
  logic [RESW-1:0]    r_res_data;
  logic               r_busy;
  logic               r_range_err;
  logic               r_op_err;

  logic [CW-1:0]      w_cand;
  logic               w_found;
  logic [IDW-1:0]     w_winner;
  logic               w_grant;
  logic [OPW-1:0]     w_op;
  logic [IDW-1:0]     w_next_ptr;
  logic               w_range_set;
  logic               w_op_set;

  // Rotating priority search starting at r_rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    w_cand   = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + CW'(k);
      if (w_cand >= N_VAL) begin
        w_cand = w_cand - N_VAL;
      end
      if (!w_found && req_valid[w_cand[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[IDW-1:0];
      end
    end
  end

  assign w_grant = issue_en & w_found;

  // One-hot grant and operand mux for the winner.
  always_comb begin
    req_ready = '0;
    w_op      = '0;
    if (w_grant) begin
      req_ready[w_winner] = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_op = req_data[i*OPW +: OPW];
      end
    end
  end

  assign red_in_valid = w_grant;
  assign red_in_data  = w_grant ? w_op : '0;

  assign w_next_ptr  = (w_winner == LAST_ID) ? '0 : w_winner + IDW'(1);
  assign w_range_set = r_tag_vld[RED_LAT-1] & (red_out_data >= Q_VAL);
  assign w_op_set    = w_grant & (|w_op[OPW-1:OPW-2]);

  // Pointer, tag pipeline, result capture and sticky flags; set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= '0;
      r_tag_vld   <= '0;
      for (int unsigned k = 0; k < RED_LAT; k++) begin
        r_tag_id[k] <= '0;
      end
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
      r_busy      <= 1'b0;
      r_range_err <= 1'b0;
      r_op_err    <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr_ptr <= w_next_ptr;
      end
      r_tag_vld[0] <= w_grant;
      r_tag_id[0]  <= w_winner;
      for (int unsigned k = 1; k < RED_LAT; k++) begin
        r_tag_vld[k] <= r_tag_vld[k-1];
        r_tag_id[k]  <= r_tag_id[k-1];
      end
      if (r_tag_vld[RED_LAT-1]) begin
        r_res_valid <= 1'b1;
        r_res_id    <= r_tag_id[RED_LAT-1];
        r_res_data  <= red_out_data;
      end else begin
        r_res_valid <= 1'b0;
      end
      // Next-state busy: a new grant or anything still in the tag pipe.
      r_busy      <= w_grant | (|r_tag_vld);
      r_range_err <= w_range_set | (r_range_err & ~err_clr);
      r_op_err    <= w_op_set | (r_op_err & ~err_clr);
    end
  end

  assign res_valid = r_res_valid;
  assign res_id    = r_res_id;
  assign res_data  = r_res_data;
  assign busy      = r_busy;
  assign range_err = r_range_err;
  assign op_err    = r_op_err;

endmodule

// File: tb/tb_d_redu_arbiter.sv
// Bench for d_redu_arbiter: behavioural reducer, event-queue reference model
// checked every cycle, directed scenarios with literal expectations, random run.
module tb_d_redu_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned RED_LAT = 2;
  localparam int unsigned Q       = 8380417;
  localparam int unsigned IDW     = 2;

  logic                  clk       = 1'b0;
  logic                  rst_n     = 1'b0;
  logic                  issue_en  = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [47:0]           op [NUM_REQ];
  logic [48*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  red_in_valid;
  logic [47:0]           red_in_data;
  logic [22:0]           red_out_data;
  logic                  res_valid;
  logic [IDW-1:0]        res_id;
  logic [22:0]           res_data;
  logic                  busy;
  logic                  range_err;
  logic                  op_err;
  logic                  err_clr   = 1'b0;
  logic                  force_max = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  d_redu_arbiter #(
    .NUM_REQ(NUM_REQ), .RED_LAT(RED_LAT), .Q(Q), .IDW(IDW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .issue_en(issue_en),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .red_in_valid(red_in_valid), .red_in_data(red_in_data),
    .red_out_data(red_out_data), .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data), .busy(busy), .range_err(range_err),
    .op_err(op_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) req_data[i*48 +: 48] = op[i];
  end

  // Behavioural reducer: x mod q (or forced q) visible RED_LAT edges after sampling.
  logic [22:0] red_pipe [RED_LAT];
  always @(posedge clk) begin
    logic [63:0] t;
    t = 64'(red_in_data) % 64'(Q);
    red_pipe[0] <= force_max ? 23'(Q) : 23'(t);
    for (int k = 1; k < int'(RED_LAT); k++) red_pipe[k] <= red_pipe[k-1];
  end
  assign red_out_data = red_pipe[RED_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Winner = valid requester at the smallest circular distance from the pointer.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int rr, input logic en);
    int n, best, bestd, d;
    n = int'(NUM_REQ);
    best = -1;
    bestd = n;
    if (!en) return -1;
    for (int i = 0; i < n; i++) begin
      if (v[i]) begin
        d = (i - rr + n) % n;
        if (d < bestd) begin
          bestd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  typedef struct {
    int          e;
    int          id;
    logic [22:0] data;
  } item_t;

  item_t          m_q[$];
  int             m_rr = 0;
  int             m_edge = 0;
  logic           m_res_valid = 1'b0;
  logic [IDW-1:0] m_res_id = '0;
  logic [22:0]    m_res_data = '0;
  logic           m_busy = 1'b0;
  logic           m_rerr = 1'b0;
  logic           m_operr = 1'b0;

  // Compare against the model, then advance the model over the coming edge.
  always @(negedge clk) begin
    int w;
    logic [NUM_REQ-1:0] e_rdy;
    logic [47:0] e_op;
    logic [63:0] t;
    item_t it;
    if (!rst_n) begin
      m_q.delete();
      m_rr = 0;
      m_res_valid = 1'b0;
      m_res_id = '0;
      m_res_data = '0;
      m_busy = 1'b0;
      m_rerr = 1'b0;
      m_operr = 1'b0;
    end
    w = pick(req_valid, m_rr, issue_en);
    e_rdy = '0;
    e_op = '0;
    if (w >= 0) begin
      e_rdy[w] = 1'b1;
      e_op = op[w];
    end
    chk("req_ready", 64'(req_ready), 64'(e_rdy));
    chk("red_in_valid", 64'(red_in_valid), 64'(w >= 0));
    chk("red_in_data", 64'(red_in_data), 64'(e_op));
    chk("res_valid", 64'(res_valid), 64'(m_res_valid));
    chk("res_id", 64'(res_id), 64'(m_res_id));
    chk("res_data", 64'(res_data), 64'(m_res_data));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("range_err", 64'(range_err), 64'(m_rerr));
    chk("op_err", 64'(op_err), 64'(m_operr));
    if (rst_n) begin
      m_edge++;
      if (err_clr) begin
        m_rerr = 1'b0;
        m_operr = 1'b0;
      end
      m_res_valid = 1'b0;
      if (m_q.size() > 0 && m_q[0].e + int'(RED_LAT) == m_edge) begin
        it = m_q.pop_front();
        m_res_valid = 1'b1;
        m_res_id = IDW'(it.id);
        m_res_data = it.data;
        if (it.data >= 23'(Q)) m_rerr = 1'b1;
      end
      if (w >= 0) begin
        t = 64'(e_op) % 64'(Q);
        it.e = m_edge;
        it.id = w;
        it.data = force_max ? 23'(Q) : 23'(t);
        m_q.push_back(it);
        m_rr = (w + 1) % int'(NUM_REQ);
        if (e_op[47:46] != 2'b00) m_operr = 1'b1;
      end
      m_busy = (m_q.size() > 0) || m_res_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [3:0] rot [8];
  int cnt;

  initial begin
    for (int i = 0; i < int'(NUM_REQ); i++) op[i] = '0;
    rot[0] = 4'h2; rot[1] = 4'h4; rot[2] = 4'h8; rot[3] = 4'h1;
    rot[4] = 4'h2; rot[5] = 4'h4; rot[6] = 4'h8; rot[7] = 4'h1;
    repeat (3) tick();
    rst_n = 1'b1;
    issue_en = 1'b1;
    tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_res_valid", 64'(res_valid), 64'd0);

    // Single requester 0, operand q+1.
    op[0] = 48'd8380418;
    req_valid = 4'b0001;
    #1 chk("single_grant", 64'(req_ready), 64'h1);
    tick();
    chk("single_busy_T1", 64'(busy), 64'd1);
    req_valid = '0;
    tick();
    chk("single_no_res_yet", 64'(res_valid), 64'd0);
    tick();
    chk("single_res_valid", 64'(res_valid), 64'd1);
    chk("single_res_id", 64'(res_id), 64'd0);
    chk("single_res_data", 64'(res_data), 64'd1);
    tick();
    chk("single_res_fall", 64'(res_valid), 64'd0);
    chk("single_busy_fall", 64'(busy), 64'd0);

    // All four requesting continuously; pointer starts at 1.
    for (int i = 0; i < 4; i++) op[i] = 48'(i) << 23;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1 chk("rotate_grant", 64'(req_ready), 64'(rot[k]));
      if (k >= 3) begin
        chk("rotate_res_valid", 64'(res_valid), 64'd1);
        chk("rotate_res_id", 64'(res_id), 64'((k - 2) % 4));
        chk("rotate_res_data", 64'(res_data), 64'(((k - 2) % 4) * 8191));
      end
      tick();
    end
    idle(5);

    // Pointer to 2 via requester 1, then 1 and 3 compete, then 0 alone after wrap.
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1010;
    #1 chk("rr_pick3", 64'(req_ready), 64'h8);
    tick();
    chk("rr_pick1", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0001;
    #1 chk("rr_wrap0", 64'(req_ready), 64'h1);
    tick();
    idle(5);

    // issue_en dropped with three operands in flight.
    req_valid = 4'b1111;
    repeat (3) tick();
    issue_en = 1'b0;
    #1 chk("halt_no_grant", 64'(req_ready), 64'h0);
    cnt = int'(res_valid);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("halt_no_grant_drain", 64'(req_ready), 64'h0);
      cnt += int'(res_valid);
    end
    chk("halt_pulse_count", 64'(cnt), 64'd3);
    chk("halt_busy_low", 64'(busy), 64'd0);
    issue_en = 1'b1;
    idle(3);

    // Forced out-of-range result and bad operand; clear; set-wins on same edge.
    force_max = 1'b1;
    op[2] = 48'h4000_0000_0000;
    req_valid = 4'b0100;
    tick();
    chk("err_op_set", 64'(op_err), 64'd1);
    req_valid = '0;
    repeat (2) tick();
    chk("err_res_data", 64'(res_data), 64'd8380417);
    chk("err_range_set", 64'(range_err), 64'd1);
    repeat (3) tick();
    chk("err_range_sticky", 64'(range_err), 64'd1);
    chk("err_op_sticky", 64'(op_err), 64'd1);
    err_clr = 1'b1;
    tick();
    chk("err_range_clr", 64'(range_err), 64'd0);
    chk("err_op_clr", 64'(op_err), 64'd0);
    req_valid = 4'b0100;
    tick();
    chk("err_op_setwins", 64'(op_err), 64'd1);
    req_valid = '0;
    tick();
    chk("err_op_cleared_next", 64'(op_err), 64'd0);
    tick();
    chk("err_range_setwins", 64'(range_err), 64'd1);
    err_clr = 1'b0;
    force_max = 1'b0;
    idle(4);

    // Asynchronous reset with two operands in flight.
    for (int i = 0; i < 4; i++) op[i] = 48'h8000_0000_0000 | 48'(i + 5);
    req_valid = 4'b1111;
    repeat (2) tick();
    chk("rst_pre_busy", 64'(busy), 64'd1);
    chk("rst_pre_op_err", 64'(op_err), 64'd1);
    #2 rst_n = 1'b0;
    req_valid = '0;
    #1;
    chk("rst_async_busy", 64'(busy), 64'd0);
    chk("rst_async_op_err", 64'(op_err), 64'd0);
    chk("rst_async_range_err", 64'(range_err), 64'd0);
    chk("rst_async_res_valid", 64'(res_valid), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_no_stale_res", 64'(res_valid), 64'd0);
    end
    req_valid = 4'b0110;
    #1 chk("rst_ptr_zero", 64'(req_ready), 64'h2);
    tick();
    idle(4);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req_valid = NUM_REQ'($urandom_range(0, 15));
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if ($urandom_range(0, 7) == 0) op[i] = {16'($urandom), 32'($urandom)};
        else op[i] = {14'd0, 2'($urandom), 32'($urandom)};
      end
      issue_en  = ($urandom_range(0, 7) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      force_max = ($urandom_range(0, 31) == 0);
      tick();
    end
    err_clr = 1'b0;
    force_max = 1'b0;
    issue_en = 1'b1;
    idle(6);
    chk("final_idle", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
